entropy_source_pool: RTL and testbench
======================================

ENTROPY_SOURCE_POOL -- requirements
Module: entropy_source_pool

Interface
REQ-001 The block SHALL have parameter LFSR_W, default 32: width of each LFSR channel, 16..64.
REQ-002 The block SHALL have parameter N_LFSR, default 2: number of parallel LFSR channels, 1..8.
REQ-003 The block SHALL have parameter LFSR_TAPS, default 32'h80200003: feedback tap mask, bit k set meaning prng[k] is tapped.
REQ-004 The block SHALL have parameter PRNG_RESET_VALUE, default 32'hABCDEF37: base seed, zero-extended or truncated to LFSR_W.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4: sample pool depth, a power of 2, at least 2.
REQ-006 The block SHALL have parameter BIST_CYCLES, default 64: startup self-test length in cycles.
REQ-007 The block SHALL have parameter RCT_LIMIT, default 4: repetition-count failure threshold.
REQ-008 The block SHALL have these ports:
- g_clk  in  1  only clock.
- g_reset  in  1  synchronous, active-high reset.
- es_entropy_req  in  1  poll of `mentropy`.
- es_entropy_opst  out  2  sample status.
- es_entropy_data  out  16  sample data.
- es_noise_test  in  1  noise-test mode.
- es_noise_wr  in  1  write to `mnoise`.
- es_noise_wdata  in  32  `mnoise` write data.
- es_noise_rdata  out  32  `mnoise` read data.

Function
REQ-009 Each channel i SHALL be an LFSR that shifts left each cycle, with new LSB equal to the XNOR of all tapped bits; all channels SHALL step every cycle except in state DEAD.
REQ-010 The raw sample SHALL be the XOR of bits [15:0] of all channels, taken combinationally from the current register values.
REQ-011 The controller SHALL be an FSM with states BIST, RUN and DEAD.
- BIST -> RUN after BIST_CYCLES cycles in BIST.
- Any state -> DEAD on a repetition-count failure.
- DEAD is left only by g_reset.
REQ-012 The repetition counter SHALL count consecutive cycles with an unchanged raw sample, clear to 0 when the sample changes, and declare a failure when the count reaches RCT_LIMIT-1; it SHALL be active in BIST and RUN.
REQ-013 es_entropy_opst SHALL be combinational and encode the status as follows: 2'b00 in BIST; 2'b01 in RUN with the pool non-empty; 2'b10 in RUN with the pool empty; 2'b11 in DEAD.
REQ-014 es_entropy_data SHALL be the pool head when opst is 2'b01, and 16'h0 otherwise.
REQ-015 The pool SHALL pop when es_entropy_req is high and opst is 2'b01; a request under any other status SHALL have no effect.
REQ-016 The pool SHALL push the raw sample when in RUN, es_noise_test is low, and the pool is not full or a pop occurs in the same cycle; a simultaneous push and pop SHALL leave the count unchanged.
REQ-017 Samples generated during BIST, DEAD or noise-test mode SHALL be discarded.
REQ-018 es_noise_rdata SHALL be {16'h0, raw sample} when es_noise_test is high, and 32'h0 otherwise.
REQ-019 When es_noise_wr and es_noise_test are both high, the block SHALL act at the next edge as follows:
- Channel i is loaded with es_noise_wdata, zero-extended or truncated to LFSR_W, then rotated left by 7*i bits modulo LFSR_W.
- The pool is flushed.
- The repetition counter is cleared.
- The FSM enters BIST with its cycle counter at 0, unless it is in DEAD.
REQ-020 A write with es_noise_test low SHALL be ignored.
REQ-021 Any channel seed, from reset or reseed, equal to all-ones (the XNOR lock-up state) SHALL be replaced with PRNG_RESET_VALUE, or with all-zeros if that value is itself all-ones.

Reset
REQ-022 On g_reset the block SHALL load channel i with PRNG_RESET_VALUE rotated left by 7*i bits, subject to REQ-021.
REQ-023 On g_reset the block SHALL empty the pool, clear the pool pointers, the BIST counter and the repetition counter, and set the state to BIST.
REQ-024 During and immediately after reset, outputs SHALL be opst=2'b00, data=16'h0 and rdata=32'h0.
REQ-025 Reset asserted mid-operation SHALL discard all pool contents and override any same-cycle request or write.

Structure
REQ-026 A shared package SHALL hold the opst encoding constants (BIST, ES16, WAIT, DEAD) and the FSM state typedef.
REQ-027 One sub-module, entropy_lfsr, SHALL implement a single channel (parameters LFSR_W and LFSR_TAPS; inputs step, load and seed; output state) and SHALL be instantiated N_LFSR times via generate.
REQ-028 The pool SHALL be an inline register FIFO, with no RAM macro.

Verification
REQ-029 Reset, then idle -> opst=00 for cycles 0..63 after reset release, opst=10 at cycle 64, opst=01 from cycle 65.
REQ-030 With es_entropy_req held high from cycle 70 for 20 cycles -> opst=01 on every cycle and data equal to the model's raw sample from the push cycle.
REQ-031 es_noise_test=1 with 4 samples pooled, then 4 requests -> 4 valid samples, then opst=10; rdata[31:16]=0 and rdata[15:0] matches the model's raw sample every cycle.
REQ-032 Noise test with a write of es_noise_wdata=32'h0 (N_LFSR=2, so identical channels give raw=0) -> opst=00, then opst=11 at the 4th cycle; opst stays 11 until g_reset.
REQ-033 Write of es_noise_wdata=32'hFFFFFFFF -> channel 0 loads 32'hABCDEF37 and no lock-up occurs.
REQ-034 Pool full (4 entries) with a request in the same cycle as a push -> count stays 4 and FIFO order is preserved.

Source files
------------

// File: rtl/entropy_source_pool_pkg.sv
// rtl/entropy_source_pool_pkg.sv - shared status encodings and controller state type
package entropy_source_pool_pkg;

  localparam logic [1:0] OPST_BIST = 2'b00;
  localparam logic [1:0] OPST_ES16 = 2'b01;
  localparam logic [1:0] OPST_WAIT = 2'b10;
  localparam logic [1:0] OPST_DEAD = 2'b11;

  typedef enum logic [1:0] {
    ST_BIST,
    ST_RUN,
    ST_DEAD
  } state_t;

endpackage

// File: rtl/entropy_lfsr.sv
// rtl/entropy_lfsr.sv - one XNOR-feedback LFSR channel with seed load
module entropy_lfsr #(
  parameter int              LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(64'h80200003)
) (
  input  logic              clk,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  // load outranks step so a reset or reseed always wins over the shift
  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], ~(^(state & LFSR_TAPS))};
    end
  end

endmodule

// File: rtl/entropy_source_pool.sv
// rtl/entropy_source_pool.sv - LFSR entropy source with self-test, health check and sample pool
module entropy_source_pool
  import entropy_source_pool_pkg::*;
#(
  parameter int          LFSR_W           = 32,
  parameter int          N_LFSR           = 2,
  parameter logic [63:0] LFSR_TAPS        = 64'h80200003,
  parameter logic [63:0] PRNG_RESET_VALUE = 64'hABCDEF37,
  parameter int          FIFO_DEPTH       = 4,
  parameter int          BIST_CYCLES      = 64,
  parameter int          RCT_LIMIT        = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        es_entropy_req,
  output logic [1:0]  es_entropy_opst,
  output logic [15:0] es_entropy_data,
  input  logic        es_noise_test,
  input  logic        es_noise_wr,
  input  logic [31:0] es_noise_wdata,
  output logic [31:0] es_noise_rdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BIST_CYCLES + 1);
  localparam int RW = $clog2(RCT_LIMIT + 1);
  localparam logic [LFSR_W-1:0] BASE_SEED = PRNG_RESET_VALUE[LFSR_W-1:0];

  // all-ones is the XNOR lock-up state, so it is never allowed in as a seed
  function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
    fix_seed = s;
    if (&s) fix_seed = (&BASE_SEED) ? '0 : BASE_SEED;
  endfunction

  function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] x, input int r);
    logic [2*LFSR_W-1:0] d;
    d    = {x, x};
    rotl = LFSR_W'(d >> (LFSR_W - r));
  endfunction

  logic [LFSR_W-1:0] ch_state [N_LFSR];
  logic [LFSR_W-1:0] wdata_w;
  logic [15:0]       raw;
  logic              do_write, lfsr_step, lfsr_load;

  state_t  state, state_next;
  logic [BW-1:0] bist_cnt;
  logic          bist_done;

  logic [RW-1:0] rct_cnt, rct_next;
  logic [15:0]   prev_raw;
  logic          rct_active, rct_fail;

  logic [15:0]   pool_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] pool_cnt;
  logic          pool_full, push, pop;

  assign do_write  = es_noise_wr & es_noise_test;
  assign wdata_w   = LFSR_W'(es_noise_wdata);
  assign lfsr_step = (state != ST_DEAD);
  assign lfsr_load = g_reset | do_write;

  for (genvar i = 0; i < N_LFSR; i++) begin : g_lfsr
    localparam int ROT = (7 * i) % LFSR_W;
    logic [LFSR_W-1:0] seed;

    assign seed = g_reset ? fix_seed(rotl(BASE_SEED, ROT))
                          : fix_seed(rotl(wdata_w, ROT));

    entropy_lfsr #(
      .LFSR_W   (LFSR_W),
      .LFSR_TAPS(LFSR_TAPS[LFSR_W-1:0])
    ) u_lfsr (
      .clk  (g_clk),
      .step (lfsr_step),
      .load (lfsr_load),
      .seed (seed),
      .state(ch_state[i])
    );
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < N_LFSR; i++) raw ^= ch_state[i][15:0];
  end

  // repetition-count health test; history reg restarts at zero on reset/reseed
  assign rct_active = (state != ST_DEAD);
  assign rct_next   = (raw == prev_raw) ? rct_cnt + RW'(1) : '0;
  assign rct_fail   = rct_active && (rct_next == RW'(RCT_LIMIT - 1));

  always_ff @(posedge g_clk) begin
    if (g_reset || do_write) begin
      rct_cnt  <= '0;
      prev_raw <= '0;
    end else if (rct_active) begin
      rct_cnt  <= rct_next;
      prev_raw <= raw;
    end
  end

  assign bist_done = (bist_cnt == BW'(BIST_CYCLES - 1));

  always_ff @(posedge g_clk) begin
    if (g_reset || do_write) begin
      bist_cnt <= '0;
    end else if (state == ST_BIST) begin
      bist_cnt <= bist_cnt + BW'(1);
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) state <= ST_BIST;
    else         state <= state_next;
  end

  // a reseed restarts self-test and outranks a same-cycle health failure
  always_comb begin
    state_next = state;
    case (state)
      ST_BIST: if (bist_done) state_next = ST_RUN;
      default: ;
    endcase
    if (rct_fail) state_next = ST_DEAD;
    if (do_write && state != ST_DEAD) state_next = ST_BIST;
  end

  always_comb begin
    es_entropy_opst = OPST_BIST;
    if (!g_reset) begin
      case (state)
        ST_RUN:  es_entropy_opst = (pool_cnt != '0) ? OPST_ES16 : OPST_WAIT;
        ST_DEAD: es_entropy_opst = OPST_DEAD;
        default: es_entropy_opst = OPST_BIST;
      endcase
    end
  end

  assign pool_full = (pool_cnt == CW'(FIFO_DEPTH));
  assign pop       = es_entropy_req && (es_entropy_opst == OPST_ES16);
  assign push      = (state == ST_RUN) && !es_noise_test && (!pool_full || pop);

  always_ff @(posedge g_clk) begin
    if (g_reset || do_write) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pool_cnt <= '0;
    end else begin
      if (push) begin
        pool_mem[wr_ptr] <= raw;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      pool_cnt <= pool_cnt + CW'(1);
      else if (pop && !push) pool_cnt <= pool_cnt - CW'(1);
    end
  end

  assign es_entropy_data = (es_entropy_opst == OPST_ES16) ? pool_mem[rd_ptr] : 16'h0;
  assign es_noise_rdata  = (es_noise_test && !g_reset) ? {16'h0, raw} : 32'h0;

endmodule

// File: tb/tb_entropy_source_pool.sv
// tb/tb_entropy_source_pool.sv - directed and randomized bench for entropy_source_pool
module tb_entropy_source_pool;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        es_entropy_req;
  logic [1:0]  es_entropy_opst;
  logic [15:0] es_entropy_data;
  logic        es_noise_test;
  logic        es_noise_wr;
  logic [31:0] es_noise_wdata;
  logic [31:0] es_noise_rdata;

  entropy_source_pool dut (
    .g_clk          (g_clk),
    .g_reset        (g_reset),
    .es_entropy_req (es_entropy_req),
    .es_entropy_opst(es_entropy_opst),
    .es_entropy_data(es_entropy_data),
    .es_noise_test  (es_noise_test),
    .es_noise_wr    (es_noise_wr),
    .es_noise_wdata (es_noise_wdata),
    .es_noise_rdata (es_noise_rdata)
  );

  always #5 g_clk = ~g_clk;

  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] BASE = 32'hABCDEF37;

  int checks   = 0;
  int failures = 0;

  // reference model: 0 = self-test, 1 = running, 2 = dead
  logic [31:0] m_ch [2];
  int          m_state = 0;
  int          m_bist  = 0;
  int          m_rct   = 0;
  logic [15:0] m_prev  = 16'h0;
  logic [15:0] m_pool [$];
  logic [1:0]  obs_opst;

  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int r);
    if (r == 0) return x;
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] m_fix(input logic [31:0] x);
    return (x == 32'hFFFFFFFF) ? BASE : x;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] x);
    return {x[30:0], ~(^(x & TAPS))};
  endfunction

  function automatic logic [15:0] m_raw();
    return m_ch[0][15:0] ^ m_ch[1][15:0];
  endfunction

  function automatic logic [1:0] m_opst();
    if (g_reset)      return 2'b00;
    if (m_state == 0) return 2'b00;
    if (m_state == 2) return 2'b11;
    return (m_pool.size() > 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [15:0] raw;
    logic [1:0]  op;
    bit          pop, push, fail;
    int          old;
    if (g_reset) begin
      for (int i = 0; i < 2; i++) m_ch[i] = m_fix(m_rotl(BASE, 7 * i));
      m_pool.delete();
      m_bist = 0; m_rct = 0; m_prev = 16'h0; m_state = 0;
      return;
    end
    raw = m_raw();
    op  = m_opst();
    old = m_state;
    if (es_noise_wr && es_noise_test) begin
      for (int i = 0; i < 2; i++) m_ch[i] = m_fix(m_rotl(es_noise_wdata, 7 * i));
      m_pool.delete();
      m_rct = 0; m_prev = 16'h0; m_bist = 0;
      if (old != 2) m_state = 0;
      return;
    end
    pop  = es_entropy_req && (op == 2'b01);
    push = (old == 1) && !es_noise_test && ((m_pool.size() < 4) || pop);
    if (pop)  void'(m_pool.pop_front());
    if (push) m_pool.push_back(raw);
    fail = 1'b0;
    if (old != 2) begin
      if (raw == m_prev) m_rct++;
      else               m_rct = 0;
      m_prev = raw;
      fail   = (m_rct == 3);
    end
    if (old == 0) begin
      if (m_bist == 63) m_state = 1;
      m_bist++;
    end
    if (fail) m_state = 2;
    if (old != 2) for (int i = 0; i < 2; i++) m_ch[i] = m_next(m_ch[i]);
  endtask

  task automatic cycle();
    logic [1:0] eo;
    @(negedge g_clk);
    eo       = m_opst();
    obs_opst = es_entropy_opst;
    check("opst", es_entropy_opst, eo);
    check("data", es_entropy_data, (eo == 2'b01) ? m_pool[0] : 16'h0);
    check("rdata", es_noise_rdata, (es_noise_test && !g_reset) ? {16'h0, m_raw()} : 32'h0);
    model_step();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_reset = 1'b1; es_entropy_req = 1'b0; es_noise_test = 1'b0;
    es_noise_wr = 1'b0; es_noise_wdata = 32'h0;
    m_ch[0] = 32'h0; m_ch[1] = 32'h0;

    cycle();
    cycle();
    check("rst_opst", obs_opst, 2'b00);
    g_reset = 1'b0;

    for (int c = 0; c < 70; c++) begin
      cycle();
      if (c < 64)       check("bist_opst", obs_opst, 2'b00);
      else if (c == 64) check("first_run_opst", obs_opst, 2'b10);
      else              check("run_opst", obs_opst, 2'b01);
    end

    // pool is full here: every cycle pops and pushes together
    es_entropy_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      check("req_opst", obs_opst, 2'b01);
      check("full_cnt", dut.pool_cnt, 4);
    end
    es_entropy_req = 1'b0;

    es_noise_test = 1'b1;
    cycle();
    cycle();
    es_entropy_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("drain_opst", obs_opst, 2'b01);
    end
    es_entropy_req = 1'b0;
    cycle();
    check("drained_opst", obs_opst, 2'b10);
    es_noise_test = 1'b0;

    for (int rep = 0; rep < 3; rep++) begin
      for (int c = 0; c < 80; c++) begin
        es_entropy_req = 1'($urandom_range(0, 1));
        cycle();
      end
      es_entropy_req = 1'b0;
      es_noise_test  = 1'b1;
      es_noise_wr    = 1'b1;
      es_noise_wdata = $urandom;
      cycle();
      es_noise_wr   = 1'b0;
      es_noise_test = 1'b0;
    end

    g_reset = 1'b1;
    cycle();
    g_reset = 1'b0;
    for (int c = 0; c < 70; c++) cycle();
    es_noise_test  = 1'b1;
    es_noise_wr    = 1'b1;
    es_noise_wdata = 32'h0;
    cycle();
    es_noise_wr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check("zero_seed_opst", obs_opst, (k < 4) ? 2'b00 : 2'b11);
    end
    es_noise_test  = 1'b0;
    es_entropy_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("dead_sticky", obs_opst, 2'b11);
    end
    es_entropy_req = 1'b0;
    g_reset = 1'b1;
    cycle();
    check("rst_from_dead", obs_opst, 2'b00);
    g_reset = 1'b0;
    cycle();
    check("post_rst_opst", obs_opst, 2'b00);

    es_noise_test  = 1'b1;
    es_noise_wr    = 1'b1;
    es_noise_wdata = 32'hFFFFFFFF;
    cycle();
    es_noise_wr = 1'b0;
    check("ch0_lockup_seed", dut.g_lfsr[0].u_lfsr.state, 32'hABCDEF37);
    check("ch1_lockup_seed", dut.g_lfsr[1].u_lfsr.state, 32'hABCDEF37);
    for (int c = 0; c < 6; c++) cycle();
    es_noise_test = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
